// File: rtl/id_exe_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded operands and controls,
// with stall hold, flush-to-bubble, and a saturating bubble counter.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [31:0] imm32_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm24_in,
  input  logic        val2_src_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  sr_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic [31:0] imm32_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm24_out,
  output logic        val2_src_out,
  output logic [3:0]  exe_cmd_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        wb_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic [3:0]  sr_out,
  output logic [15:0] bubble_cnt
);

  logic load;      // data fields update
  logic bubble;    // a bubble lands in the register this edge
  logic ctl_keep;  // side-effecting controls pass through

  assign load     = flush | ~freeze;
  assign bubble   = flush | (~freeze & ~valid_in);
  assign ctl_keep = ~flush & valid_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm32_out         <= '0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      val2_src_out      <= 1'b0;
      exe_cmd_out       <= '0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      sr_out            <= '0;
      bubble_cnt        <= '0;
    end else begin
      if (load) begin
        valid_out         <= ctl_keep;
        pc_out            <= pc_in;
        val_rn_out        <= val_rn_in;
        val_rm_out        <= val_rm_in;
        imm32_out         <= imm32_in;
        shift_operand_out <= shift_operand_in;
        signed_imm24_out  <= signed_imm24_in;
        val2_src_out      <= val2_src_in;
        exe_cmd_out       <= exe_cmd_in;
        mem_r_en_out      <= mem_r_en_in & ctl_keep;
        mem_w_en_out      <= mem_w_en_in & ctl_keep;
        wb_en_out         <= wb_en_in & ctl_keep;
        b_out             <= b_in & ctl_keep;
        s_out             <= s_in & ctl_keep;
        dest_out          <= dest_in;
        src1_out          <= src1_in;
        src2_out          <= src2_in;
        sr_out            <= sr_in;
      end
      // Saturate rather than wrap so a long flush storm stays visible.
      if (bubble && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed table, hand sequences for stall/flush/reset/
// saturation, and randomized traffic checked against a rule-level model.
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rn, rm, imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic        v2s;
    logic [3:0]  cmd;
    logic        mr, mw, wb, b, s;
    logic [3:0]  dest, src1, src2, sr;
  } fields_t;

  typedef struct packed {
    fields_t     d;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    logic fz, fl, vin, ctl_in;
    logic exp_valid, exp_ctl;
    int   exp_inc;
  } vec_t;

  logic    clk = 0, rst_n = 0, freeze = 0, flush = 0;
  fields_t i;
  out_t    act, exp_o;
  int      checks = 0, errors = 0;

  logic        valid_out, val2_src_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out, imm32_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
  logic [15:0] bubble_cnt;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .valid_in(i.valid), .pc_in(i.pc), .val_rn_in(i.rn), .val_rm_in(i.rm),
    .imm32_in(i.imm), .shift_operand_in(i.shop), .signed_imm24_in(i.simm),
    .val2_src_in(i.v2s), .exe_cmd_in(i.cmd), .mem_r_en_in(i.mr),
    .mem_w_en_in(i.mw), .wb_en_in(i.wb), .b_in(i.b), .s_in(i.s),
    .dest_in(i.dest), .src1_in(i.src1), .src2_in(i.src2), .sr_in(i.sr),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .imm32_out(imm32_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .val2_src_out(val2_src_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .sr_out(sr_out), .bubble_cnt(bubble_cnt)
  );

  assign act = {valid_out, pc_out, val_rn_out, val_rm_out, imm32_out,
                shift_operand_out, signed_imm24_out, val2_src_out, exe_cmd_out,
                mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out,
                dest_out, src1_out, src2_out, sr_out, bubble_cnt};

  // Rule-level model: what the register should hold after one edge.
  function automatic out_t model(out_t cur, fields_t in, logic fz, logic fl);
    out_t n = cur;
    logic is_bubble = fl || (!fz && !in.valid);
    if (fl || !fz) begin
      n.d = in;
      if (fl || !in.valid) begin
        n.d.valid = 0; n.d.mr = 0; n.d.mw = 0; n.d.wb = 0; n.d.b = 0; n.d.s = 0;
      end
    end
    if (is_bubble && cur.cnt < 16'hFFFF) n.cnt = cur.cnt + 16'd1;
    return n;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return f;
  endfunction

  task automatic cmp(input string name, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("%s FAIL actual=%h expected=%h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_o = model(exp_o, i, freeze, flush);
  endtask

  task automatic do_reset();
    rst_n = 0; #3;
    exp_o = '0;
    cmp("reset_all_zero", act, '0);
    @(negedge clk); rst_n = 1;
  endtask

  vec_t vt[8];
  logic [15:0] c0;

  initial begin
    i = '0;
    exp_o = '0;
    #2;
    do_reset();

    // Single capture of known values
    i = '0; i.valid = 1; i.pc = 32'h10; i.rm = 32'hF0; i.shop = 12'h0A0; i.wb = 1;
    tick();
    cmp("cap_pc", pc_out, 32'h10);
    cmp("cap_rm", val_rm_out, 32'hF0);
    cmp("cap_shop", shift_operand_out, 12'h0A0);
    cmp("cap_wb_valid", {wb_en_out, valid_out}, 2'b11);
    cmp("cap_cnt", bubble_cnt, 16'd0);
    cmp("cap_model", act, exp_o);

    // Directed table: control gating and bubble counting
    vt[0] = '{0,0,1,1, 1,1,0};
    vt[1] = '{1,0,0,0, 1,1,0};
    vt[2] = '{1,1,1,1, 0,0,1};
    vt[3] = '{1,0,1,1, 0,0,0};
    vt[4] = '{0,0,0,1, 0,0,1};
    vt[5] = '{0,0,1,0, 1,0,0};
    vt[6] = '{0,1,1,1, 0,0,1};
    vt[7] = '{0,0,1,1, 1,1,0};
    foreach (vt[k]) begin
      c0 = bubble_cnt;
      i = rand_fields();
      i.valid = vt[k].vin;
      {i.mr, i.mw, i.wb, i.b, i.s} = {5{vt[k].ctl_in}};
      freeze = vt[k].fz; flush = vt[k].fl;
      tick();
      cmp($sformatf("tbl%0d_valid", k), valid_out, vt[k].exp_valid);
      cmp($sformatf("tbl%0d_ctl", k), {mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out},
          {5{vt[k].exp_ctl}});
      cmp($sformatf("tbl%0d_cnt", k), bubble_cnt, c0 + 16'(vt[k].exp_inc));
      cmp($sformatf("tbl%0d_model", k), act, exp_o);
    end
    freeze = 0; flush = 0;

    // Stall holds everything
    i = rand_fields(); i.valid = 1; i.rn = 32'hAAAA;
    tick();
    c0 = bubble_cnt;
    freeze = 1;
    for (int k = 0; k < 3; k++) begin
      i = rand_fields(); i.rn = 32'h5555;
      tick();
      cmp("stall_rn", val_rn_out, 32'hAAAA);
      cmp("stall_cnt", bubble_cnt, c0);
    end
    cmp("stall_model", act, exp_o);

    // Flush wins over freeze
    flush = 1; i.valid = 1; i.mw = 1;
    c0 = bubble_cnt;
    tick();
    cmp("flushfz_valid_mw", {valid_out, mem_w_en_out}, 2'b00);
    cmp("flushfz_cnt", bubble_cnt, c0 + 16'd1);
    freeze = 0; flush = 0;

    // Invalid instruction suppresses controls
    i.valid = 0; i.wb = 1; i.b = 1;
    c0 = bubble_cnt;
    tick();
    cmp("inv_wb_b", {wb_en_out, b_out}, 2'b00);
    cmp("inv_cnt", bubble_cnt, c0 + 16'd1);

    // Async reset mid-cycle while valid_out=1
    i = rand_fields(); i.valid = 1;
    tick();
    cmp("pre_rst_valid", valid_out, 1'b1);
    #2;
    do_reset();

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      i = rand_fields();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 6) == 0);
      tick();
      cmp($sformatf("rand%0d", k), act, exp_o);
    end
    freeze = 0; flush = 0;

    // Saturation: drive the counter to 0xFFFE with back-to-back flushes
    #2;
    do_reset();
    flush = 1;
    repeat (65534) tick();
    cmp("sat_pre", bubble_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp($sformatf("sat%0d", k), bubble_cnt, 16'hFFFF);
    end
    flush = 0; i.valid = 0;
    tick();
    cmp("sat_hold", bubble_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
